// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder: decodes controller strobes, tracks DDRAM address,
// models busy timing. Optional 4-bit interface enabled by defining LCD_RESP_4BIT_EN.
module lcd_bus_responder #(
  parameter int unsigned BUSY_SHORT = 2000,
  parameter int unsigned BUSY_LONG  = 76000
) (
  input  logic         SYS_clk,
  input  logic         SYS_reset,
  input  logic [14:4]  pin,
  output logic [7:0]   rd_data,
  output logic         rd_oe,
  output logic         char_valid,
  output logic [7:0]   char_code,
  output logic [6:0]   char_addr,
  output logic         busy,
  output logic [6:0]   ddram_addr,
  output logic [2:0]   disp_ctrl,
  output logic         proto_err
);

  localparam int unsigned BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);

  typedef enum logic [1:0] {IDLE, STROBE, EXEC} state_t;

  state_t           state;
  logic [14:4]      sync1, sync2;
  logic             e_d;
  logic             e_s, rs_s, rw_s;
  logic [7:0]       db_s;
  logic             e_rise_c, e_fall_c;
  logic             cmd_pend, cmd_rs;
  logic [7:0]       cmd_db;
  logic             long_cmd_c;
  logic             inc_dec;
  logic [CNT_W-1:0] busy_cnt;
  logic [7:0]       status_c;
`ifdef LCD_RESP_4BIT_EN
  logic             four_bit;
  logic             nib_phase;
  logic [3:0]       nib_hi;
`endif

  assign e_s      = sync2[6];
  assign rs_s     = sync2[4];
  assign rw_s     = sync2[5];
  assign db_s     = sync2[14:7];
  assign e_rise_c = e_s & ~e_d;
  assign e_fall_c = ~e_s & e_d;

  // Clear Display and Return Home are the only slow instructions
  assign long_cmd_c = ~cmd_rs && (cmd_db[7:2] == 6'b0) && (cmd_db[1:0] != 2'b0);

  // Read-back value: status for instruction reads, zero for data reads
  assign status_c = rs_s ? 8'h00 : {busy, ddram_addr};

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      sync1      <= '0;
      sync2      <= '0;
      e_d        <= 1'b0;
      state      <= IDLE;
      rd_data    <= 8'h00;
      rd_oe      <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= 8'h00;
      char_addr  <= 7'h00;
      busy       <= 1'b0;
      ddram_addr <= 7'h00;
      disp_ctrl  <= 3'b000;
      proto_err  <= 1'b0;
      cmd_pend   <= 1'b0;
      cmd_rs     <= 1'b0;
      cmd_db     <= 8'h00;
      inc_dec    <= 1'b1;
      busy_cnt   <= '0;
`ifdef LCD_RESP_4BIT_EN
      four_bit   <= 1'b0;
      nib_phase  <= 1'b0;
      nib_hi     <= 4'h0;
`endif
    end else begin
      sync1      <= pin;
      sync2      <= sync1;
      e_d        <= e_s;
      char_valid <= 1'b0;
      proto_err  <= 1'b0;
      cmd_pend   <= 1'b0;

      // Busy countdown; a freshly executed command below reloads it
      if (busy) begin
        if (busy_cnt == '0) busy <= 1'b0;
        else                busy_cnt <= busy_cnt - CNT_W'(1);
      end

      // Read strobe: drive status from E rising until E falling
      if (e_fall_c) begin
        rd_oe   <= 1'b0;
        rd_data <= 8'h00;
      end else if ((e_rise_c && rw_s) || rd_oe) begin
        rd_oe <= 1'b1;
`ifdef LCD_RESP_4BIT_EN
        rd_data <= (four_bit && nib_phase) ? {status_c[3:0], 4'h0} : status_c;
`else
        rd_data <= status_c;
`endif
      end

      case (state)
        IDLE: begin
          if (e_rise_c) state <= STROBE;
        end
        STROBE: begin
          if (e_fall_c) begin
            state <= IDLE;
            if (rw_s) begin
`ifdef LCD_RESP_4BIT_EN
              if (four_bit) nib_phase <= ~nib_phase;
`endif
            end else if (busy) begin
              proto_err <= 1'b1;
            end else begin
`ifdef LCD_RESP_4BIT_EN
              if (four_bit && !nib_phase) begin
                nib_hi    <= db_s[7:4];
                nib_phase <= 1'b1;
              end else begin
                nib_phase <= 1'b0;
                cmd_pend  <= 1'b1;
                cmd_rs    <= rs_s;
                cmd_db    <= four_bit ? {nib_hi, db_s[7:4]} : db_s;
                state     <= EXEC;
              end
`else
              cmd_pend <= 1'b1;
              cmd_rs   <= rs_s;
              cmd_db   <= db_s;
              state    <= EXEC;
`endif
            end
          end
        end
        EXEC: begin
          if (e_rise_c)                   state <= STROBE;
          else if (busy && busy_cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Latched command takes effect one cycle after the falling edge
      if (cmd_pend) begin
        busy     <= 1'b1;
        busy_cnt <= long_cmd_c ? CNT_W'(BUSY_LONG - 1) : CNT_W'(BUSY_SHORT - 1);
        if (cmd_rs) begin
          char_valid <= 1'b1;
          char_code  <= cmd_db;
          char_addr  <= ddram_addr;
          ddram_addr <= inc_dec ? ddram_addr + 7'd1 : ddram_addr - 7'd1;
        end else begin
          casez (cmd_db)
            8'b1???????: ddram_addr <= cmd_db[6:0];
            8'b01??????: ;
            8'b001?????: begin
`ifdef LCD_RESP_4BIT_EN
              four_bit <= ~cmd_db[4];
              if (cmd_db[4]) nib_phase <= 1'b0;
`endif
            end
            8'b0001????: ;
            8'b00001???: disp_ctrl <= cmd_db[2:0];
            8'b000001??: inc_dec <= cmd_db[1];
            8'b0000001?: ddram_addr <= 7'h00;
            8'b00000001: begin
              ddram_addr <= 7'h00;
              inc_dec    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder; character events and drop pulses are
// checked by a monitor, status/timing by the stimulus thread.
module tb_lcd_bus_responder;

  typedef struct packed {
    logic [7:0] code;
    logic [6:0] addr;
  } char_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_rs = 1'b0, p_rw = 1'b0, p_e = 1'b0;
  logic [7:0]  p_db = 8'h00;
  logic [14:4] pin;
  logic [7:0]  rd_data, char_code;
  logic        rd_oe, char_valid, busy, proto_err;
  logic [6:0]  char_addr, ddram_addr;
  logic [2:0]  disp_ctrl;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    busy_cycles = 0;
  int    proto_seen  = 0;
  int    proto_exp   = 0;
  char_t exp_q[$];
  logic [7:0] rv;
  logic       ov;

  assign pin = {p_db, p_e, p_rw, p_rs};

  always #5 clk = ~clk;

  lcd_bus_responder #(.BUSY_SHORT(4), .BUSY_LONG(16)) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst),
    .pin       (pin),
    .rd_data   (rd_data),
    .rd_oe     (rd_oe),
    .char_valid(char_valid),
    .char_code (char_code),
    .char_addr (char_addr),
    .busy      (busy),
    .ddram_addr(ddram_addr),
    .disp_ctrl (disp_ctrl),
    .proto_err (proto_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // One full E strobe; samples the read-back bus while E is high
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] db,
                        output logic [7:0] rdv, output logic oev);
    p_rs = rs; p_rw = rw; p_db = db; p_e = 1'b0;
    repeat (2) @(posedge clk);
    #1 p_e = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rdv = rd_data;
    oev = rd_oe;
    @(posedge clk);
    #1 p_e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic rs, input logic [7:0] db);
    logic [7:0] d;
    logic       o;
    strobe(rs, 1'b0, db, d, o);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Busy-cycle counter sampled away from the active edge
  initial forever begin
    @(negedge clk);
    if (busy) busy_cycles++;
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (char_valid) begin
        if (exp_q.size() == 0) begin
          check("char_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          char_t e;
          e = exp_q.pop_front();
          check("char_code", 32'(char_code), 32'(e.code));
          check("char_addr", 32'(char_addr), 32'(e.addr));
        end
      end
      if (proto_err) proto_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(ddram_addr), 32'd0);
    check("rst_disp", 32'(disp_ctrl), 32'd0);
    check("rst_rd_oe", 32'(rd_oe), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Function Set: short busy, address untouched
    busy_cycles = 0;
    wr(1'b0, 8'h38);
    wait_idle("idle_38");
    check("busy_len_short", 32'(busy_cycles), 32'd4);
    check("addr_after_38", 32'(ddram_addr), 32'd0);

    // Entry mode increment and two characters
    wr(1'b0, 8'h06); wait_idle("idle_06");
    exp_q.push_back('{code: 8'h41, addr: 7'h00});
    wr(1'b1, 8'h41); wait_idle("idle_41");
    exp_q.push_back('{code: 8'h42, addr: 7'h01});
    wr(1'b1, 8'h42); wait_idle("idle_42");
    check("addr_after_chars", 32'(ddram_addr), 32'd2);

    // Set address 0x40, decrement mode, then wrap-around from 0
    wr(1'b0, 8'hC0); wait_idle("idle_c0");
    wr(1'b0, 8'h04); wait_idle("idle_04");
    exp_q.push_back('{code: 8'h5A, addr: 7'h40});
    wr(1'b1, 8'h5A); wait_idle("idle_5a");
    check("addr_dec", 32'(ddram_addr), 32'h3F);
    wr(1'b0, 8'h80); wait_idle("idle_80");
    check("addr_set0", 32'(ddram_addr), 32'h00);
    exp_q.push_back('{code: 8'h33, addr: 7'h00});
    wr(1'b1, 8'h33); wait_idle("idle_33");
    check("addr_wrap", 32'(ddram_addr), 32'h7F);

    // Clear Display: busy flag visible during long execution
    busy_cycles = 0;
    wr(1'b0, 8'h01);
    strobe(1'b0, 1'b1, 8'h00, rv, ov);
    check("rd_busy_data", 32'(rv), 32'h80);
    check("rd_busy_oe", 32'(ov), 32'd1);
    wait_idle("idle_01");
    check("busy_len_long", 32'(busy_cycles), 32'd16);
    strobe(1'b0, 1'b1, 8'h00, rv, ov);
    check("rd_idle_data", 32'(rv), 32'h00);
    check("rd_idle_oe", 32'(ov), 32'd1);

    // Write while busy is dropped; busy keeps its schedule
    busy_cycles = 0;
    wr(1'b0, 8'h01);
    proto_exp++;
    wr(1'b1, 8'h77);
    wait_idle("idle_drop");
    check("busy_len_drop", 32'(busy_cycles), 32'd16);
    check("addr_after_drop", 32'(ddram_addr), 32'd0);

    // Sub-cycle E glitch never produces a command
    wr(1'b0, 8'h06); wait_idle("idle_06b");
    p_rs = 1'b1; p_rw = 1'b0; p_db = 8'h99;
    @(posedge clk); #1 p_e = 1'b1;
    #3 p_e = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_addr", 32'(ddram_addr), 32'd0);

    // Status vs data reads at a nonzero address
    wr(1'b0, 8'h95); wait_idle("idle_95");
    check("addr_95", 32'(ddram_addr), 32'h15);
    strobe(1'b0, 1'b1, 8'h00, rv, ov);
    check("rd_status", 32'(rv), 32'h15);
    strobe(1'b1, 1'b1, 8'h00, rv, ov);
    check("rd_dataread", 32'(rv), 32'h00);
    check("rd_dataread_oe", 32'(ov), 32'd1);

    // Reset in the middle of execution
    wr(1'b0, 8'h0F);
    check("disp_on", 32'(disp_ctrl), 32'h7);
    check("busy_mid_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_disp", 32'(disp_ctrl), 32'd0);
    check("midrst_addr", 32'(ddram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{code: 8'h55, addr: 7'h00});
    wr(1'b1, 8'h55); wait_idle("idle_55");
    check("addr_resume", 32'(ddram_addr), 32'd1);

`ifdef LCD_RESP_4BIT_EN
    // 4-bit mode: one character as two nibble strobes
    wr(1'b0, 8'h28); wait_idle("idle_28");
    exp_q.push_back('{code: 8'h41, addr: 7'h01});
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h10);
    wait_idle("idle_nib");
    check("addr_nib", 32'(ddram_addr), 32'd2);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("char_queue_empty", 32'(exp_q.size()), 32'd0);
    check("proto_err_count", 32'(proto_seen), 32'(proto_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_SHORT, default 2000, busy cycles for normal instruction or data write (40 us at 50 MHz).
REQ-002 SHALL have parameter BUSY_LONG, default 76000, busy cycles for Clear Display / Return Home (1.52 ms at 50 MHz).
REQ-003 SHALL have port SYS_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port SYS_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pin  input  [14:4]  LCD bus from controller: pin[4]=RS, pin[5]=RW, pin[6]=E, pin[14:7]=DB[7:0].
REQ-006 SHALL have port rd_data  output  8  read-back byte {busy, ddram_addr}.
REQ-007 SHALL have port rd_oe  output  1  high while rd_data is driven.
REQ-008 SHALL have port char_valid  output  1  one-cycle pulse per accepted data write.
REQ-009 SHALL have port char_code  output  8  character byte, valid with char_valid.
REQ-010 SHALL have port char_addr  output  7  DDRAM address of char_code, valid with char_valid.
REQ-011 SHALL have port busy  output  1  instruction executing.
REQ-012 SHALL have port ddram_addr  output  7  current address counter.
REQ-013 SHALL have port disp_ctrl  output  3  {D, C, B} from last Display On/Off.
REQ-014 SHALL have port proto_err  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL pass E, RS, RW, DB through a 2-flop synchronizer before use; RS/RW/DB are sampled from the synchronized copy.
REQ-016 SHALL use FSM states IDLE, STROBE, EXEC: IDLE->STROBE on synchronized E rising; STROBE->EXEC on E falling with an accepted write; STROBE->IDLE on E falling for a read or a dropped write; EXEC->IDLE when the busy counter reaches zero.
REQ-017 SHALL latch RS, RW and DB on the synchronized E falling edge; the command takes effect the following cycle.
REQ-018 SHALL decode an RS=0 write by highest set bit: 0x01 Clear (addr=0, I/D=1, BUSY_LONG); 0x02-0x03 Return Home (addr=0, BUSY_LONG); 0x04-0x07 Entry Mode (store I/D=DB[1]); 0x08-0x0F Display Ctrl (disp_ctrl=DB[2:0]); 0x10-0x3F stored/ignored except Function Set DL; 0x80-0xFF Set DDRAM (addr=DB[6:0]); 0x40-0x7F (CGRAM) no effect but busy.
REQ-019 SHALL, on an RS=1 write, pulse char_valid with char_code=DB and char_addr=pre-update addr, then add +1 (I/D=1) or -1 (I/D=0) modulo 128.
REQ-020 SHALL assert busy from the cycle after the accepted write through BUSY_SHORT or BUSY_LONG cycles, then deassert.
REQ-021 SHALL, for RS=0 RW=1, drive rd_oe=1 and rd_data={busy, ddram_addr} from synchronized E rising until synchronized E falling; a read never starts busy.
REQ-022 SHALL drop any write arriving while busy=1 (no state change, busy counter not restarted) and pulse proto_err.
REQ-023 SHALL treat RS=1 RW=1 (data read) as a read returning 0x00 on rd_data with rd_oe=1.
REQ-024 SHALL ignore E pulses shorter than 1 synchronized cycle (no edge pair seen = no command).

Reset
REQ-025 SHALL, on SYS_reset=1 at any time including mid-strobe or mid-EXEC, force FSM=IDLE, busy=0, ddram_addr=0, I/D=1, disp_ctrl=3'b000, rd_oe=0, rd_data=0, char_valid=0, char_code=0, char_addr=0, proto_err=0, interface mode 8-bit, synchronizers cleared.
REQ-026 SHALL resume normal decoding on the first E rising edge after SYS_reset deasserts.

Configuration
REQ-027 SHALL, with LCD_RESP_4BIT_EN defined, honour Function Set (0x20-0x3F) DL bit: DL=0 selects 4-bit mode, where each byte is two strobes on DB[7:4], high nibble first, and reads return high then low nibble; nibble phase resets on reset or DL=1.
REQ-028 SHALL, without LCD_RESP_4BIT_EN, ignore DL and always operate 8-bit; no nibble logic is synthesized.

Verification (bench parameters BUSY_SHORT=4, BUSY_LONG=16)
REQ-029 SHALL cover: reset then write RS=0 DB=0x38 -> busy high exactly 4 cycles, ddram_addr=0.
REQ-030 SHALL cover: write 0x06, then RS=1 DB=0x41, 0x42 -> char_valid pulses with (0x41, addr 0), (0x42, addr 1); ddram_addr=2.
REQ-031 SHALL cover: write 0xC0 then 0x04 then RS=1 0x5A -> char_addr=0x40, ddram_addr=0x3F; write 0x80, 0x04, data -> ddram_addr wraps 0x00->0x7F.
REQ-032 SHALL cover: write 0x01, read busy flag during EXEC -> rd_data=0x80, rd_oe=1; after 16 cycles read -> rd_data=0x00.
REQ-033 SHALL cover: RS=1 write during busy -> proto_err one pulse, no char_valid, busy ends on original schedule.
REQ-034 SHALL cover: SYS_reset asserted mid-EXEC after 0x0F -> busy=0, disp_ctrl=000 immediately; with LCD_RESP_4BIT_EN, 0x28 then nibbles 0x4,0x1 at RS=1 -> char_code=0x41.
